// File: rtl/decode_stage.sv
// decode_stage: one-entry registered instruction-decode stage.
// Holds a 16-bit instruction in an IR behind a valid/ready handshake and
// presents decoded fields combinationally from that IR. A separate registered
// path turns the one-hot nsel into a register index, flagging bad selects.
module decode_stage #(
  parameter int DW     = 16,
  parameter int NSEL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [NSEL_W-1:0] nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [2:0]        cond,
  output logic [1:0]        shift,
  output logic [DW-1:0]     sximm5,
  output logic [DW-1:0]     sximm8,
  output logic [2:0]        readnum_a,
  output logic [2:0]        readnum_b,
  output logic [2:0]        writenum,
  output logic              wr_hint,
  output logic [2:0]        sel_num,
  output logic              sel_err
);

  logic [15:0] ir;
  logic [2:0]  rn, rd, rm;
  logic        accept;

  // Select encodings; any other pattern, including reserved upper bits, is illegal.
  localparam logic [NSEL_W-1:0] SEL_RM = NSEL_W'(3'b001);
  localparam logic [NSEL_W-1:0] SEL_RD = NSEL_W'(3'b010);
  localparam logic [NSEL_W-1:0] SEL_RN = NSEL_W'(3'b100);

  // Flush blocks acceptance so a redirect never admits the word on the bus.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Handshake and IR: reset beats flush, flush beats accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ir        <= 16'h0000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ir        <= in_instr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];

  assign opcode    = ir[15:13];
  assign op        = ir[12:11];
  assign ALUop     = ir[12:11];
  assign cond      = ir[10:8];
  assign shift     = ir[4:3];
  assign sximm5    = {{(DW-5){ir[4]}}, ir[4:0]};
  assign sximm8    = {{(DW-8){ir[7]}}, ir[7:0]};
  assign readnum_a = rn;
  // STR reads the store data from Rd instead of Rm.
  assign readnum_b = (opcode == 3'b100) ? rd : rm;

  // Destination index and register-file write hint by instruction class.
  always_comb begin
    writenum = rd;
    wr_hint  = 1'b0;
    case (opcode)
      3'b110: begin
        if (op == 2'b10) begin
          writenum = rn;
          wr_hint  = 1'b1;
        end else if (op == 2'b00) begin
          wr_hint  = 1'b1;
        end
      end
      3'b101:  wr_hint = (op != 2'b01);
      3'b011:  wr_hint = 1'b1;
      default: wr_hint = 1'b0;
    endcase
  end

  // Registered nsel decode from the current IR, independent of the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_num <= 3'd0;
      sel_err <= 1'b0;
    end else begin
      case (nsel)
        SEL_RM: begin sel_num <= rm;   sel_err <= 1'b0; end
        SEL_RD: begin sel_num <= rd;   sel_err <= 1'b0; end
        SEL_RN: begin sel_num <= rn;   sel_err <= 1'b0; end
        default: begin sel_num <= 3'd0; sel_err <= 1'b1; end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with a DW=16 and a DW=32 instance.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [15:0] in_instr;
  logic [2:0]  nsel;

  logic        in_ready, out_valid, wr_hint, sel_err;
  logic [2:0]  opcode, cond, readnum_a, readnum_b, writenum, sel_num;
  logic [1:0]  op, ALUop, shift;
  logic [15:0] sximm5, sximm8;

  logic        in_ready_w, out_valid_w, wr_hint_w, sel_err_w;
  logic [2:0]  opcode_w, cond_w, readnum_a_w, readnum_b_w, writenum_w, sel_num_w;
  logic [1:0]  op_w, ALUop_w, shift_w;
  logic [31:0] sximm5_w, sximm8_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.DW(16), .NSEL_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .nsel(nsel), .opcode(opcode), .op(op), .ALUop(ALUop), .cond(cond), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .writenum(writenum), .wr_hint(wr_hint), .sel_num(sel_num), .sel_err(sel_err)
  );

  decode_stage #(.DW(32), .NSEL_W(3)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
    .nsel(nsel), .opcode(opcode_w), .op(op_w), .ALUop(ALUop_w), .cond(cond_w), .shift(shift_w),
    .sximm5(sximm5_w), .sximm8(sximm8_w), .readnum_a(readnum_a_w), .readnum_b(readnum_b_w),
    .writenum(writenum_w), .wr_hint(wr_hint_w), .sel_num(sel_num_w), .sel_err(sel_err_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] words [4];
  logic [2:0]  nsel_seq [5];
  logic [2:0]  num_exp  [5];
  logic        err_exp  [5];

  initial begin
    words[0] = 16'h6123; words[1] = 16'hA4E3; words[2] = 16'h8147; words[3] = 16'hD2FF;
    nsel_seq[0] = 3'b100; nsel_seq[1] = 3'b010; nsel_seq[2] = 3'b001;
    nsel_seq[3] = 3'b011; nsel_seq[4] = 3'b000;
    num_exp[0] = 3'd4; num_exp[1] = 3'd7; num_exp[2] = 3'd3; num_exp[3] = 3'd0; num_exp[4] = 3'd0;
    err_exp[0] = 1'b0; err_exp[1] = 1'b0; err_exp[2] = 1'b0; err_exp[3] = 1'b1; err_exp[4] = 1'b1;

    // Reset then idle
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 16'h0000; nsel = 3'b001;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_sximm8",    64'(sximm8),    64'd0);
    chk("rst_sel_num",   64'(sel_num),   64'd0);
    chk("rst_sel_err",   64'(sel_err),   64'd0);
    chk("rst_wr_hint",   64'(wr_hint),   64'd0);

    // Single accept: MOV Rn=1, #0xA5
    in_instr = 16'hD1A5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("acc_out_valid", 64'(out_valid), 64'd1);
    chk("acc_opcode",    64'(opcode),    64'd6);
    chk("acc_op",        64'(op),        64'd2);
    chk("acc_writenum",  64'(writenum),  64'd1);
    chk("acc_wr_hint",   64'(wr_hint),   64'd1);
    chk("acc_sximm8",    64'(sximm8),    64'hFFA5);
    chk("acc_sximm8_32", 64'(sximm8_w),  64'hFFFF_FFA5);
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Back-to-back stream, one word per cycle
    for (int i = 0; i < 4; i++) begin
      in_instr = words[i]; in_valid = 1'b1;
      #1;
      chk("strm_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("strm_out_valid", 64'(out_valid), 64'd1);
      chk("strm_sximm8", 64'(sximm8), 64'({{8{words[i][7]}}, words[i][7:0]}));
      chk("strm_opcode", 64'(opcode), 64'(words[i][15:13]));
    end
    in_valid = 1'b0;
    tick();
    chk("strm_end_valid", 64'(out_valid), 64'd0);

    // Stall for 3 cycles, then release
    out_ready = 1'b0; in_instr = 16'hB0C1; in_valid = 1'b1;
    tick();
    chk("stall_first_valid", 64'(out_valid), 64'd1);
    in_instr = 16'h6E12;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_sximm8",   64'(sximm8),   64'hFFC1);
      tick();
    end
    chk("stall_hold_sximm8", 64'(sximm8), 64'hFFC1);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("release_valid",  64'(out_valid), 64'd1);
    chk("release_sximm8", 64'(sximm8),    64'h0012);
    tick();
    chk("release_drain", 64'(out_valid), 64'd0);

    // Flush with a simultaneous incoming word
    in_instr = 16'h6055; in_valid = 1'b1;
    tick();
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    in_instr = 16'h60AA; flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl_never_out", 64'(out_valid), 64'd0);

    // nsel path on ADD Rn=4, Rd=7, Rm=3
    in_instr = 16'hA4E3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_readnum_b", 64'(readnum_b), 64'd3);
    chk("add_readnum_a", 64'(readnum_a), 64'd4);
    chk("add_wr_hint",   64'(wr_hint),   64'd1);
    for (int i = 0; i < 5; i++) begin
      nsel = nsel_seq[i];
      tick();
      chk("nsel_num", 64'(sel_num), 64'(num_exp[i]));
      chk("nsel_err", 64'(sel_err), 64'(err_exp[i]));
    end
    nsel = 3'b001;
    tick();
    chk("nsel_recover_err", 64'(sel_err), 64'd0);
    chk("nsel_recover_num", 64'(sel_num), 64'd3);

    // STR: readnum_b from Rd, no write
    in_instr = 16'h8147; in_valid = 1'b1;
    tick();
    chk("str_readnum_b", 64'(readnum_b), 64'd2);
    chk("str_wr_hint",   64'(wr_hint),   64'd0);

    // CMP: no write, writenum=Rd, sximm5=5
    in_instr = 16'hA925;
    tick();
    chk("cmp_wr_hint",  64'(wr_hint),  64'd0);
    chk("cmp_writenum", 64'(writenum), 64'd1);
    chk("cmp_sximm5",   64'(sximm5),   64'd5);

    // LDR writes Rd; negative imm5 sign-extends
    in_instr = 16'h6153;
    tick();
    chk("ldr_wr_hint",   64'(wr_hint),   64'd1);
    chk("ldr_writenum",  64'(writenum),  64'd2);
    chk("ldr_sximm5",    64'(sximm5),    64'hFFF3);
    chk("ldr_sximm5_32", 64'(sximm5_w),  64'hFFFF_FFF3);

    // Reset mid-operation overrides flush and accept
    in_instr = 16'hD1A5; in_valid = 1'b1; flush = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid",  64'(out_valid), 64'd0);
    chk("mid_rst_sximm8", 64'(sximm8),    64'd0);
    chk("mid_rst_opcode", 64'(opcode),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
